// File: rtl/mpu_pkg.sv
// mpu_pkg: shared MPU sizes and sequencer state encoding
package mpu_pkg;
  localparam int MATRIX_DIM = 5;
  localparam int ELEM_WIDTH = 8;
  localparam int ELEM_COUNT = MATRIX_DIM * MATRIX_DIM;
  localparam int IDX_WIDTH = $clog2(ELEM_COUNT);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, STREAM, DONE} state_t;
endpackage

// File: rtl/mpu_sub_element.sv
// mpu_sub_element: single element a - b, wrapping or signed-saturating
module mpu_sub_element #(
  parameter int WIDTH = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             sat
);
  logic [WIDTH:0] d;
  always_comb begin
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    sat = SATURATE && (d[WIDTH] != d[WIDTH-1]);
    diff = sat ? {d[WIDTH], {(WIDTH-1){~d[WIDTH]}}} : d[WIDTH-1:0];
  end
endmodule

// File: rtl/mpu_sub_sequencer.sv
// mpu_sub_sequencer: loads A then B into one buffer, subtracts in place, streams A-B out
module mpu_sub_sequencer
  import mpu_pkg::*;
#(
  parameter int DIM = MATRIX_DIM,
  parameter int WIDTH = ELEM_WIDTH,
  parameter bit SATURATE = 1'b0,
  localparam int N = DIM * DIM,
  localparam int IW = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_index,
  output logic             sat_flag
);
  state_t state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] mem [N];
  logic [WIDTH-1:0] diff;
  logic sat_e, sat_nxt, in_fire, out_fire, last;

  mpu_sub_element #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_sub (
    .a(mem[cnt]), .b(in_data), .diff(diff), .sat(sat_e)
  );

  assign busy = state != IDLE;
  assign done = state == DONE;
  assign in_ready = state == LOAD_A || state == LOAD_B;
  assign out_valid = state == STREAM;
  assign out_data = out_valid ? mem[cnt] : '0;
  assign out_index = cnt;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last = cnt == IW'(N - 1);

  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    sat_nxt = sat_flag;
    case (state)
      IDLE: if (start) begin
        state_nxt = LOAD_A;
        cnt_nxt = '0;
        sat_nxt = 1'b0;
      end
      LOAD_A, LOAD_B: if (in_fire) begin
        cnt_nxt = last ? '0 : cnt + 1'b1;
        state_nxt = !last ? state : (state == LOAD_A) ? LOAD_B : STREAM;
        sat_nxt = sat_flag | (state == LOAD_B && sat_e);
      end
      STREAM: if (out_fire) begin
        cnt_nxt = last ? '0 : cnt + 1'b1;
        state_nxt = last ? DONE : STREAM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      sat_flag <= sat_nxt;
    end
  end

  // buffer holds A after LOAD_A and A-B after LOAD_B; no reset needed
  always_ff @(posedge clock)
    if (in_fire) mem[cnt] <= (state == LOAD_A) ? in_data : diff;
endmodule

// File: tb/tb_mpu_sub_sequencer.sv
// tb_mpu_sub_sequencer: directed checks on wrapping and saturating sequencer instances
module tb_mpu_sub_sequencer;
  localparam int N = 25;
  logic clock = 0, reset = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic busy0, done0, in_ready0, out_valid0, sat0;
  logic busy1, done1, in_ready1, out_valid1, sat1;
  logic [7:0] od0, od1;
  logic [4:0] oi0, oi1;
  logic [7:0] va [N], vb [N], e0 [N], e1 [N];
  int total = 0, passed = 0, fails = 0, ticks = 0;

  mpu_sub_sequencer #(.SATURATE(1'b0)) u0 (
    .clock(clock), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(od0),
    .out_index(oi0), .sat_flag(sat0)
  );
  mpu_sub_sequencer #(.SATURATE(1'b1)) u1 (
    .clock(clock), .reset(reset), .start(start), .busy(busy1), .done(done1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(od1),
    .out_index(oi1), .sat_flag(sat1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    ticks++;
  endtask

  task automatic feed(input bit gaps, input bit pulse_start, input int abort_at);
    start = 1;
    ticks = 0;
    tick;
    start = 0;
    for (int k = 0; k < 2 * N; k++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
          in_valid = 0;
          in_data = 8'hEE;
          tick;
        end
      in_data = k < N ? va[k] : vb[k-N];
      in_valid = 1;
      if (k == abort_at) begin
        reset = 1;
        tick;
        reset = 0;
        in_valid = 0;
        return;
      end
      start = pulse_start && k == N + 3;
      chk("in_ready", {in_ready1, in_ready0}, 2'b11);
      tick;
      start = 0;
    end
    in_valid = 0;
  endtask

  task automatic drain(input bit stall, input bit s1, input bit timed);
    out_ready = 1;
    for (int k = 0; k < N; k++) begin
      chk("out_valid", {out_valid1, out_valid0}, 2'b11);
      chk("out_index", {oi1, oi0}, {5'(k), 5'(k)});
      chk("out_data_wrap", od0, e0[k]);
      chk("out_data_sat", od1, e1[k]);
      if (stall && k == 7) begin
        out_ready = 0;
        repeat (3) begin
          tick;
          chk("stall_valid", {out_valid1, out_valid0}, 2'b11);
          chk("stall_index", {oi1, oi0}, {5'd7, 5'd7});
          chk("stall_data", {od1, od0}, {e1[7], e0[7]});
        end
        out_ready = 1;
      end
      tick;
    end
    out_ready = 0;
    chk("done", {done1, done0}, 2'b11);
    chk("done_out_valid", {out_valid1, out_valid0}, 2'b00);
    if (timed) chk("done_cycle", ticks, 76);
    chk("sat_flag", {sat1, sat0}, {s1, 1'b0});
    tick;
    chk("done_once", {done1, done0}, 2'b00);
    chk("back_idle", {busy1, busy0}, 2'b00);
  endtask

  initial begin
    repeat (2) tick;
    reset = 0;
    chk("rst_busy", {busy1, busy0}, 2'b00);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_in_ready", {in_ready1, in_ready0}, 2'b00);
    chk("rst_out_valid", {out_valid1, out_valid0}, 2'b00);
    chk("rst_out_data", {od1, od0}, 16'h0);
    chk("rst_out_index", {oi1, oi0}, 10'h0);
    chk("rst_sat", {sat1, sat0}, 2'b00);

    for (int k = 0; k < N; k++) begin
      va[k] = 8'(k + 10); vb[k] = 8'(k); e0[k] = 8'd10; e1[k] = 8'd10;
    end
    feed(0, 0, -1);
    chk("first_valid", {out_valid1, out_valid0}, 2'b11);
    drain(0, 0, 1);

    for (int k = 0; k < N; k++) begin
      va[k] = 8'h05; vb[k] = 8'h07; e0[k] = 8'hFE; e1[k] = 8'hFE;
    end
    tick;
    feed(0, 0, -1);
    drain(0, 0, 1);

    for (int k = 0; k < N; k++) begin
      va[k] = 8'(k); vb[k] = 8'(k); e0[k] = 8'h00; e1[k] = 8'h00;
    end
    va[0] = 8'h80; vb[0] = 8'h01; e0[0] = 8'h7F; e1[0] = 8'h80;
    va[1] = 8'h7F; vb[1] = 8'hFF; e0[1] = 8'h80; e1[1] = 8'h7F;
    feed(0, 0, -1);
    drain(0, 1, 1);

    for (int k = 0; k < N; k++) begin
      va[k] = 8'(3 * k); vb[k] = 8'(k + 1); e0[k] = 8'(2 * k - 1); e1[k] = 8'(2 * k - 1);
    end
    feed(1, 0, -1);
    drain(1, 0, 0);

    in_valid = 1;
    in_data = 8'hAA;
    repeat (3) begin
      tick;
      chk("idle_in_ready", {in_ready1, in_ready0}, 2'b00);
      chk("idle_busy", {busy1, busy0}, 2'b00);
    end
    for (int k = 0; k < N; k++) begin
      va[k] = 8'(k + 10); vb[k] = 8'(k); e0[k] = 8'd10; e1[k] = 8'd10;
    end
    feed(0, 1, -1);
    drain(0, 0, 1);

    feed(0, 0, N + 12);
    chk("abort_busy", {busy1, busy0}, 2'b00);
    chk("abort_out_valid", {out_valid1, out_valid0}, 2'b00);
    chk("abort_done", {done1, done0}, 2'b00);
    repeat (3) begin
      tick;
      chk("abort_no_done", {done1, done0}, 2'b00);
    end
    for (int k = 0; k < N; k++) begin
      va[k] = 8'h05; vb[k] = 8'h07; e0[k] = 8'hFE; e1[k] = 8'hFE;
    end
    feed(0, 0, -1);
    drain(0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
